// File: rtl/port_uart_tx.sv
// 32-bit word to 4-byte UART serializer (LSB byte first, 8N1 frames).
// Optional even parity bit per frame when PORT_UART_PARITY_EN is defined.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WriteStrobe,
  input  logic [31:0] WriteData,
  output logic        TxD,
  output logic        Busy,
  output logic        Done,
  output logic        Overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PORT_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
`ifdef PORT_UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic cnt_end;
  assign cnt_end = (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
`ifdef PORT_UART_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != S_IDLE) cnt_d = cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (WriteStrobe) begin
          state_d = S_START;
          cnt_d   = 16'd0;
          shift_d = WriteData;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
        end
      end
      S_START: begin
        if (cnt_end) begin
          state_d  = S_DATA;
          cnt_d    = 16'd0;
`ifdef PORT_UART_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          cnt_d    = 16'd0;
          // The word drains LSB first, so bytes come out in ascending order.
          shift_d  = {1'b0, shift_q[31:1]};
`ifdef PORT_UART_PARITY_EN
          parity_d = parity_q ^ shift_q[0];
`endif
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
`ifdef PORT_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef PORT_UART_PARITY_EN
      S_PARITY: begin
        if (cnt_end) begin
          state_d = S_STOP;
          cnt_d   = 16'd0;
        end
      end
`endif
      S_STOP: begin
        if (cnt_end) begin
          cnt_d = 16'd0;
          if (byte_q == 2'd3) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (WriteStrobe && (state_q != S_IDLE)) overrun_d = 1'b1;

    // TxD is decoded from the next state so the line is registered yet has no extra lag.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef PORT_UART_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!reset) begin
      // NOTE: the shift register is cleared too, so no stale word survives an abort.
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shift_q   <= 32'd0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PORT_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef PORT_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign TxD     = txd_q;
  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: queue-based line model compared every cycle, plus
// directed words with hand-computed byte, timing and flag expectations.
module tb_port_uart_tx;

  localparam int CPB = 4;
`ifdef PORT_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        WriteStrobe;
  logic [31:0] WriteData;
  logic        TxD, Busy, Done, Overrun;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  port_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .WriteStrobe(WriteStrobe), .WriteData(WriteData),
    .TxD(TxD), .Busy(Busy), .Done(Done), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of per-cycle line levels still to be sent for the current word.
  bit   exp_q[$];
  logic exp_done = 1'b0;
  logic exp_over = 1'b0;

  task automatic push_word(input logic [31:0] w);
    logic [7:0] b;
    logic       fb[$];
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      fb.delete();
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(b[i]);
`ifdef PORT_UART_PARITY_EN
      fb.push_back(^b);
`endif
      fb.push_back(1'b1);
      foreach (fb[j]) repeat (CPB) exp_q.push_back(fb[j]);
    end
  endtask

  initial begin
    bit busy_before;
    forever begin
      @(posedge clk);
      busy_before = (exp_q.size() != 0);
      if (!reset) begin
        exp_q.delete();
        exp_done = 1'b0;
        exp_over = 1'b0;
      end else begin
        exp_done = 1'b0;
        if (busy_before) begin
          void'(exp_q.pop_front());
          exp_done = (exp_q.size() == 0);
        end
        if (WriteStrobe) begin
          if (!busy_before) push_word(WriteData);
          else exp_over = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle after the first (reset) edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("txd",     TxD,     (exp_q.size() == 0) ? 1'b1 : exp_q[0]);
      check("busy",    Busy,    exp_q.size() != 0);
      check("done",    Done,    exp_done);
      check("overrun", Overrun, exp_over);
      if (Done === 1'b1) done_count++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] w);
    WriteStrobe = 1'b1;
    WriteData   = w;
    @(posedge clk);
    @(negedge clk);
    WriteStrobe = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", Done, 1'b1);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int t = 0;
    b = 8'h00;
    while (TxD !== 1'b0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("rx_start_found", TxD, 1'b0);
    if (TxD !== 1'b0) return;
    repeat (2) @(negedge clk);
    check("rx_start", TxD, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = TxD;
    end
`ifdef PORT_UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    check("rx_parity", TxD, ^b);
`endif
    repeat (CPB) @(negedge clk);
    check("rx_stop", TxD, 1'b1);
  endtask

  initial begin
    logic [7:0] rb [4];
    int n;
    int dc0;

    // Reset with a coincident strobe that must be ignored.
    reset       = 1'b0;
    WriteStrobe = 1'b1;
    WriteData   = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    WriteStrobe = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_txd",     TxD,     1'b1);
    check("rst_busy",    Busy,    1'b0);
    check("rst_done",    Done,    1'b0);
    check("rst_overrun", Overrun, 1'b0);
    repeat (3) @(negedge clk);

    // 0xA5: frame 0,1,0,1,0,0,1,0,1,1 then three zero bytes; Done 160 cycles after first low.
    send(32'h0000_00A5);
    check("a5_first_low", TxD, 1'b0);
    fork
      for (int k = 0; k < 4; k++) recv_byte(rb[k]);
      wait_done(n);
    join
    check("a5_byte0", rb[0], 8'hA5);
    check("a5_byte1", rb[1], 8'h00);
    check("a5_byte2", rb[2], 8'h00);
    check("a5_byte3", rb[3], 8'h00);
`ifdef PORT_UART_PARITY_EN
    check("a5_done_cycle", n, 176);
`else
    check("a5_done_cycle", n, 160);
`endif
    repeat (4) @(negedge clk);

    // 0xDEADBEEF with a second strobe at cycle 20: ignored, sets Overrun.
    send(32'hDEAD_BEEF);
    fork
      for (int k = 0; k < 4; k++) recv_byte(rb[k]);
      begin
        repeat (20) @(negedge clk);
        WriteStrobe = 1'b1;
        WriteData   = 32'h1111_1111;
        @(negedge clk);
        WriteStrobe = 1'b0;
      end
    join
    check("ovr_flag",  Overrun, 1'b1);
    check("ovr_byte0", rb[0], 8'hEF);
    check("ovr_byte1", rb[1], 8'hBE);
    check("ovr_byte2", rb[2], 8'hAD);
    check("ovr_byte3", rb[3], 8'hDE);
    wait_done(n);

    // Strobe in the Done cycle is accepted; TxD low one cycle later.
    send(32'h0000_0001);
    check("donecyc_txd",  TxD,  1'b0);
    check("donecyc_busy", Busy, 1'b1);

    // Reset 50 cycles into the word aborts it without a Done pulse.
    repeat (49) @(negedge clk);
    dc0 = done_count;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_txd",     TxD,     1'b1);
    check("abort_busy",    Busy,    1'b0);
    check("abort_overrun", Overrun, 1'b0);
    repeat (200) @(negedge clk);
    check("abort_no_done", done_count - dc0, 0);

    // 0x12345678 after the abort: bytes 78,56,34,12 back to back, one Done.
    dc0 = done_count;
    send(32'h1234_5678);
    fork
      for (int k = 0; k < 4; k++) recv_byte(rb[k]);
      wait_done(n);
    join
    repeat (5) @(negedge clk);
    check("w2_byte0", rb[0], 8'h78);
    check("w2_byte1", rb[1], 8'h56);
    check("w2_byte2", rb[2], 8'h34);
    check("w2_byte3", rb[3], 8'h12);
    check("w2_done_once", done_count - dc0, 1);
    check("w2_done_cycle", n, 16 * FRAME_BITS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
